baud_gen_frac: RTL
==================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the integer divisor and the period counter.
REQ-002 SHALL have parameter FRAC_W, default 4: width of the fractional divisor and the accumulator.
REQ-003 SHALL have parameter OSR, default 16: oversample ratio (integer >= 2, not required to be a power of two); OSR_W = clog2(OSR).
REQ-004 SHALL have port CLK, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port SET, input, 1 bit: load configuration and restart the generator.
REQ-007 SHALL have port DIV_INT, input, CNT_W bits: integer CLK cycles per oversample tick; sampled only on SET.
REQ-008 SHALL have port DIV_FRAC, input, FRAC_W bits: fractional cycles, in units of 1/2^FRAC_W; sampled only on SET.
REQ-009 SHALL have port EN, input, 1 bit: count enable.
REQ-010 SHALL have port RESYNC, input, 1 bit: phase realign pulse, driven by the receiver on the start-bit edge.
REQ-011 SHALL have port OS_TICK, output, 1 bit: oversample tick, a single-cycle pulse.
REQ-012 SHALL have port BIT_TICK, output, 1 bit: bit tick, a single-cycle pulse.
REQ-013 SHALL have port OS_PHASE, output, OSR_W bits: current oversample phase.
REQ-014 SHALL have port ACTIVE, output, 1 bit: a valid configuration is loaded.
REQ-015 SHALL have port CFG_ERR, output, 1 bit: the last SET carried an illegal divisor.

Function
REQ-016 SHALL hold the following state: div_int_r, div_frac_r, a period counter cnt (CNT_W+1 bits), accumulator acc (FRAC_W bits), a carry flag, and phase (0..OSR-1).
REQ-017 SHALL operate in two states, IDLE (ACTIVE=0) and RUN (ACTIVE=1); reset enters IDLE.
REQ-018 On SET, SHALL load div_int_r/div_frac_r and clear cnt, acc, carry and phase, with no tick in that cycle.
REQ-019 On SET, SHALL go to IDLE with CFG_ERR=1 if DIV_INT < 2, otherwise go to RUN with CFG_ERR=0.
REQ-020 SET SHALL take priority over RESYNC and EN; SET during RUN restarts immediately.
REQ-021 In IDLE, SHALL hold OS_TICK=BIT_TICK=0 and freeze all counters; RESYNC and EN are ignored.
REQ-022 In RUN with EN=0, SHALL freeze cnt, acc, carry and phase and emit no ticks.
REQ-023 In RUN with EN=1, the period limit SHALL be lim = div_int_r + carry, computed at CNT_W+1 bits so there is no overflow at the maximum DIV_INT.
REQ-024 When cnt == lim-1, SHALL assert OS_TICK that cycle, set cnt to 0, set {carry,acc} <= acc + div_frac_r, and advance phase, wrapping OSR-1 -> 0.
REQ-025 When cnt != lim-1, SHALL increment cnt.
REQ-026 The first period after SET or RESYNC SHALL be exactly div_int_r cycles, since carry=0.
REQ-027 Any 2^FRAC_W consecutive OS_TICK periods SHALL total exactly 2^FRAC_W*div_int_r + div_frac_r cycles, with each period being either div_int_r or div_int_r+1.
REQ-028 SHALL assert BIT_TICK = OS_TICK AND (phase == OSR-1); BIT_TICK therefore occurs every OSR oversample ticks.
REQ-029 In RUN, RESYNC=1 SHALL clear cnt, acc and carry, set phase to OSR/2 (integer division), and suppress both ticks that cycle.
REQ-030 After RESYNC, the first BIT_TICK SHALL follow after OSR - OSR/2 OS_TICKs, i.e. at mid-bit.
REQ-031 RESYNC held for multiple cycles SHALL re-apply each cycle, with no ticks while high.
REQ-032 SHALL ignore changes on DIV_INT/DIV_FRAC without SET.
REQ-033 OS_TICK and BIT_TICK SHALL be decoded from registered state only, with no path from the EN or RESYNC inputs to the outputs other than suppression.
REQ-034 OS_PHASE SHALL equal phase and be valid in all states.

Reset
REQ-035 RST low SHALL asynchronously clear all state: div_int_r=0, div_frac_r=0, cnt=0, acc=0, carry=0, phase=0, state=IDLE.
REQ-036 While RST is low, outputs SHALL be OS_TICK=0, BIT_TICK=0, OS_PHASE=0, ACTIVE=0, CFG_ERR=0.
REQ-037 A reset asserted mid-operation SHALL abort the current period with no partial tick; a SET is required after reset deassertion to resume.

Verification
REQ-038 Defaults, SET at cycle 0 with DIV_INT=4, DIV_FRAC=0, EN=1 -> OS_TICK at cycles 4, 8, 12, ...; BIT_TICK first at cycle 64, then every 64 cycles.
REQ-039 DIV_INT=4, DIV_FRAC=8 -> OS_TICK periods 4, 4, 5, 4, 5, ...; 16 consecutive periods total 72 cycles.
REQ-040 SET with DIV_INT=1, or DIV_INT=0 -> CFG_ERR=1, ACTIVE=0, no ticks for 1000 cycles; a later SET with DIV_INT=10 -> CFG_ERR=0 and the first OS_TICK 10 cycles after SET.
REQ-041 DIV_INT=4, EN low for 7 cycles mid-period -> no ticks, OS_PHASE/cnt held; after EN returns high, the period resumes with its remaining cycles only.
REQ-042 DIV_INT=4, RESYNC pulse at phase 3 -> OS_PHASE=8 the next cycle; the first BIT_TICK exactly 8 OS_TICKs (32 cycles) after RESYNC.
REQ-043 Reset mid-period, and SET plus RESYNC in the same cycle -> all outputs 0 while RST is low; in the SET+RESYNC case SET wins (phase=0, first OS_TICK div_int_r cycles later).

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversample and bit ticks derived from an integer
// plus fractional divisor, with start-bit phase realignment for a UART receiver.

module baud_gen_frac_chk #(
  parameter int OSR_W = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             os_tick,
  input logic             bit_tick,
  input logic             active,
  input logic             cfg_err,
  input logic [OSR_W-1:0] phase
);

  // Tick and status relationships that must hold in every cycle out of reset.
  a_bit_implies_os: assert property (@(posedge clk) disable iff (!rst) bit_tick |-> os_tick);
  a_os_needs_run:   assert property (@(posedge clk) disable iff (!rst) os_tick |-> active);
  a_os_single:      assert property (@(posedge clk) disable iff (!rst) os_tick |=> !os_tick);
  a_status_excl:    assert property (@(posedge clk) disable iff (!rst) active |-> !cfg_err);
  a_phase_known:    assert property (@(posedge clk) disable iff (!rst) !$isunknown(phase));

endmodule

module baud_gen_frac #(
  parameter  int CNT_W  = 16,
  parameter  int FRAC_W = 4,
  parameter  int OSR    = 16,
  localparam int OSR_W  = $clog2(OSR)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SET,
  input  logic [CNT_W-1:0]  DIV_INT,
  input  logic [FRAC_W-1:0] DIV_FRAC,
  input  logic              EN,
  input  logic              RESYNC,
  output logic              OS_TICK,
  output logic              BIT_TICK,
  output logic [OSR_W-1:0]  OS_PHASE,
  output logic              ACTIVE,
  output logic              CFG_ERR
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r,      state_s;
  logic [CNT_W-1:0]    div_int_r,    div_int_s;
  logic [FRAC_W-1:0]   div_frac_r,   div_frac_s;
  logic [CNT_W:0]      cnt_r,        cnt_s;
  logic [FRAC_W-1:0]   acc_r,        acc_s;
  logic                carry_r,      carry_s;
  logic [OSR_W-1:0]    phase_r,      phase_s;
  logic                cfg_err_r,    cfg_err_s;

  logic [CNT_W:0]      lim_s;
  logic                wrap_s;
  logic                fire_s;
  logic                phase_last_s;
  logic [FRAC_W:0]     sum_s;

  // Period limit is one wider than the divisor so DIV_INT = max plus carry cannot wrap.
  always_comb begin
    lim_s        = {1'b0, div_int_r} + {{CNT_W{1'b0}}, carry_r};
    wrap_s       = (cnt_r == (lim_s - {{CNT_W{1'b0}}, 1'b1}));
    sum_s        = {1'b0, acc_r} + {1'b0, div_frac_r};
    phase_last_s = (phase_r == OSR_W'(OSR - 1));
    fire_s       = (state_r == ST_RUN) && EN && !RESYNC && !SET && wrap_s;
  end

  // Next-state and datapath update; SET outranks RESYNC, which outranks EN.
  always_comb begin
    state_s    = state_r;
    div_int_s  = div_int_r;
    div_frac_s = div_frac_r;
    cnt_s      = cnt_r;
    acc_s      = acc_r;
    carry_s    = carry_r;
    phase_s    = phase_r;
    cfg_err_s  = cfg_err_r;
    if (SET) begin
      div_int_s  = DIV_INT;
      div_frac_s = DIV_FRAC;
      cnt_s      = {(CNT_W+1){1'b0}};
      acc_s      = {FRAC_W{1'b0}};
      carry_s    = 1'b0;
      phase_s    = {OSR_W{1'b0}};
      if (DIV_INT < CNT_W'(2)) begin
        state_s   = ST_IDLE;
        cfg_err_s = 1'b1;
      end else begin
        state_s   = ST_RUN;
        cfg_err_s = 1'b0;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (RESYNC) begin
            cnt_s   = {(CNT_W+1){1'b0}};
            acc_s   = {FRAC_W{1'b0}};
            carry_s = 1'b0;
            phase_s = OSR_W'(OSR / 2);
          end else if (EN) begin
            if (wrap_s) begin
              cnt_s            = {(CNT_W+1){1'b0}};
              {carry_s, acc_s} = sum_s;
              if (phase_last_s) begin
                phase_s = {OSR_W{1'b0}};
              end else begin
                phase_s = phase_r + OSR_W'(1);
              end
            end else begin
              cnt_s = cnt_r + {{CNT_W{1'b0}}, 1'b1};
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= ST_IDLE;
      div_int_r  <= {CNT_W{1'b0}};
      div_frac_r <= {FRAC_W{1'b0}};
      cnt_r      <= {(CNT_W+1){1'b0}};
      acc_r      <= {FRAC_W{1'b0}};
      carry_r    <= 1'b0;
      phase_r    <= {OSR_W{1'b0}};
      cfg_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_int_r  <= div_int_s;
      div_frac_r <= div_frac_s;
      cnt_r      <= cnt_s;
      acc_r      <= acc_s;
      carry_r    <= carry_s;
      phase_r    <= phase_s;
      cfg_err_r  <= cfg_err_s;
    end
  end

  // Ticks decode registered state; inputs can only suppress them.
  assign OS_TICK  = fire_s;
  assign BIT_TICK = fire_s & phase_last_s;
  assign OS_PHASE = phase_r;
  assign ACTIVE   = (state_r == ST_RUN);
  assign CFG_ERR  = cfg_err_r;

  baud_gen_frac_chk #(
    .OSR_W (OSR_W)
  ) u_chk (
    .clk      (CLK),
    .rst      (RST),
    .os_tick  (OS_TICK),
    .bit_tick (BIT_TICK),
    .active   (ACTIVE),
    .cfg_err  (CFG_ERR),
    .phase    (OS_PHASE)
  );

endmodule
